alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command offered.
REQ-006 The block SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at a clk edge.
REQ-007 The block SHALL have port cmd_op  input  2  operation: 00 ADD, 01 SUB, 10 PAR, 11 COMP.
REQ-008 The block SHALL have ports cmd_a and cmd_b  input  DATA_WIDTH  operands.
REQ-009 The block SHALL have port alu_data  output  DATA_WIDTH  operand bus to datapath.
REQ-010 The block SHALL have port opcode_value  output  2  opcode to datapath.
REQ-011 The block SHALL have ports store_a, store_b, start  output  1 each  datapath controls.
REQ-012 The block SHALL have ports alu_done  input  1, result  input  DATA_WIDTH, overflow  input  1  datapath returns.
REQ-013 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-014 The block SHALL have ports rsp_result  output  DATA_WIDTH, rsp_overflow  output  1, rsp_error  output  1  response payload.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, START, WAIT, RESP; datapath controls are decoded from registered state only.
REQ-017 cmd_ready SHALL be 1 only in IDLE; on acceptance cmd_op/cmd_a/cmd_b are latched internally and the FSM goes to LOAD_A.
REQ-018 LOAD_A SHALL drive store_a=1, alu_data=latched a, for exactly one cycle, then go to LOAD_B.
REQ-019 LOAD_B SHALL drive store_b=1, alu_data=latched b, for exactly one cycle, then go to START.
REQ-020 store_a and store_b SHALL never be high in the same cycle, and neither SHALL be high with start.
REQ-021 START and WAIT SHALL drive start=1 and opcode_value=latched op; opcode_value SHALL stay stable from LOAD_A until leaving WAIT; START lasts one cycle then goes to WAIT.
REQ-022 In IDLE, RESP: start/store_a/store_b=0, alu_data=0, opcode_value=latched op.
REQ-023 WAIT SHALL count cycles from 1; on alu_done=1 it captures result into rsp_result, overflow into rsp_overflow (forced 0 for PAR/COMP), rsp_error=0, and goes to RESP.
REQ-024 If alu_done is still 0 when the WAIT count reaches TIMEOUT, the block SHALL go to RESP with rsp_result=0, rsp_overflow=0, rsp_error=1.
REQ-025 alu_done in the same cycle the count reaches TIMEOUT SHALL be treated as success (done wins).
REQ-026 alu_done outside WAIT SHALL be ignored.
REQ-027 RESP SHALL hold rsp_valid=1 and a stable payload until rsp_ready=1 at a clk edge, then go to IDLE; rsp_ready outside RESP is ignored.
REQ-028 Minimum command-to-rsp_valid latency SHALL be 5 cycles (accept edge, LOAD_A, LOAD_B, START, WAIT with alu_done); back-to-back throughput one command per 6 cycles.
REQ-029 The RESP->IDLE edge SHALL NOT accept a new command; acceptance requires cmd_ready high, i.e. the following cycle.
REQ-030 rsp_result/rsp_overflow/rsp_error SHALL hold their last value in IDLE until overwritten by the next WAIT exit.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, cmd_ready=1 after release, busy=0, store_a=store_b=start=0, alu_data=0, opcode_value=0, rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_error=0, WAIT counter=0, latched operands=0.
REQ-032 Reset asserted mid-command (any state) SHALL abort the command with no response generated.

Verification
REQ-033 ADD a=8'h7F b=8'h01, alu_done after 1 WAIT cycle with result=8'h80 overflow=1 -> store_a, store_b, start pulses in order, rsp_valid 5 cycles after accept, rsp_result=8'h80, rsp_overflow=1, rsp_error=0.
REQ-034 PAR command, datapath returns overflow=1 -> rsp_overflow=0.
REQ-035 alu_done never asserted, TIMEOUT=15 -> rsp_valid after 15 WAIT cycles with rsp_error=1, rsp_result=0.
REQ-036 rsp_ready held 0 for 10 cycles in RESP with cmd_valid=1 -> payload stable, cmd_ready=0, no store pulses; one cycle after rsp_ready=1 the next command is accepted.
REQ-037 rst pulsed during WAIT -> all outputs at reset values asynchronously, no rsp_valid, next command completes normally.
REQ-038 alu_done arriving exactly on WAIT cycle 15 -> success response, rsp_error=0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the command, datapath and response signals of
// alu_sequencer.
//   cmd_*          command handshake and operands (valid/ready)
//   alu_data, opcode_value, store_a, store_b, start
//                  controls toward the ALU datapath
//   alu_done, result, overflow
//                  returns from the ALU datapath
//   rsp_*          response handshake and payload (valid/ready)
//   busy           sequencer is not idle
// Modports: master = command source / datapath / response sink,
//           slave  = the sequencer itself.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;

    logic [DATA_WIDTH-1:0] alu_data;
    logic [1:0]            opcode_value;
    logic                  store_a;
    logic                  store_b;
    logic                  start;

    logic                  alu_done;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_overflow;
    logic                  rsp_error;

    logic                  busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_done, result, overflow,
        output rsp_ready,
        input  cmd_ready, alu_data, opcode_value, store_a, store_b, start,
        input  rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_done, result, overflow,
        input  rsp_ready,
        output cmd_ready, alu_data, opcode_value, store_a, store_b, start,
        output rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command at a time, loads operand A then B
// into an external datapath over a shared bus, starts it, waits for alu_done
// (bounded by TIMEOUT cycles) and returns the result through a valid/ready
// response channel.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_sequencer_if.slave (command, datapath controls/returns,
//          response payload, busy)
// Parameters:
//   DATA_WIDTH - operand/result width
//   TIMEOUT    - maximum WAIT cycles before the command is aborted (1..255)
module alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state;
    state_t                state_next;

    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  ov_q;
    logic                  err_q;
    logic [7:0]            wait_cnt;

    logic                  accept;
    logic                  done_hit;
    logic                  timeout_hit;

    // State register plus the registers loaded on FSM events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            ov_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                op_q <= bus.cmd_op;
                a_q  <= bus.cmd_a;
                b_q  <= bus.cmd_b;
            end

            // wait_cnt holds the number of the current WAIT cycle (1-based).
            if (state == START) begin
                wait_cnt <= 8'd1;
            end else if (state == WAIT && state_next == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (done_hit) begin
                res_q <= bus.result;
                // PAR and COMP (op[1]=1) have no arithmetic overflow.
                ov_q  <= bus.overflow & ~op_q[1];
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                res_q <= '0;
                ov_q  <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    // Next-state logic and Moore decode of all controls from the state register.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        done_hit      = 1'b0;
        timeout_hit   = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.store_a   = 1'b0;
        bus.store_b   = 1'b0;
        bus.start     = 1'b0;
        bus.alu_data  = '0;
        bus.rsp_valid = 1'b0;

        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                bus.store_a  = 1'b1;
                bus.alu_data = a_q;
                state_next   = LOAD_B;
            end
            LOAD_B: begin
                bus.store_b  = 1'b1;
                bus.alu_data = b_q;
                state_next   = START;
            end
            START: begin
                bus.start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                bus.start = 1'b1;
                // done is checked first so a completion on the last allowed
                // cycle still counts as success.
                if (bus.alu_done) begin
                    done_hit   = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.opcode_value = op_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_overflow = ov_q;
    assign bus.rsp_error    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed stimulus for alu_sequencer,
// checked every cycle against a command-timeline model kept in the bench,
// plus literal expectations for the headline scenarios.
module tb_alu_sequencer;
    localparam int DW  = 8;
    localparam int TMO = 15;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: a command's life is measured in cycles k after its accept edge.
    // k=1 load A, k=2 load B, k=3 start, k=4..3+w wait, k=4+w response.
    bit          m_active;
    int          m_k, m_w, m_d;
    logic [DW-1:0] m_a, m_b, m_dres;
    logic        m_dov;
    logic [1:0]  m_op;
    logic [DW-1:0] m_res;
    logic        m_ov, m_err;

    // Datapath behaviour for the next accepted command.
    int          nd;
    logic [DW-1:0] nres;
    logic        nov;
    bit          noise;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_k = 0; m_w = 0; m_d = 0;
        m_op = '0; m_a = '0; m_b = '0;
        m_res = '0; m_ov = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_active) begin
            if (bus.cmd_valid) begin
                m_active = 1'b1;
                m_k  = 1;
                m_a  = bus.cmd_a;
                m_b  = bus.cmd_b;
                m_op = bus.cmd_op;
                m_d  = nd;
                m_dres = nres;
                m_dov  = nov;
                m_w  = (nd <= TMO) ? nd : TMO;
            end
        end else if (m_k == 4 + m_w) begin
            if (bus.rsp_ready) m_active = 1'b0;
        end else begin
            m_k++;
            if (m_k == 4 + m_w) begin
                if (m_d <= TMO) begin
                    m_res = m_dres;
                    m_ov  = m_dov & ~m_op[1];
                    m_err = 1'b0;
                end else begin
                    m_res = '0;
                    m_ov  = 1'b0;
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_dp();
        bit in_wait;
        bit hit;
        in_wait = m_active && m_k >= 4 && m_k <= 3 + m_w;
        if (in_wait) begin
            hit = (m_k - 3 == m_d);
            bus.alu_done = hit;
            bus.result   = hit ? m_dres : DW'($urandom);
            bus.overflow = hit ? m_dov : 1'($urandom);
        end else if (noise) begin
            bus.alu_done = 1'($urandom);
            bus.result   = DW'($urandom);
            bus.overflow = 1'($urandom);
        end else begin
            bus.alu_done = 1'b0;
            bus.result   = '0;
            bus.overflow = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        drive_dp();
    endtask

    task automatic drain();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && m_active; i++) tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int d, input logic [DW-1:0] res, input logic ov);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        nd = d; nres = res; nov = ov;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges until rsp_valid, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("rsp_valid_bound", bus.rsp_valid, 1);
    endtask

    // Per-cycle comparison against the model.
    logic [DW-1:0] e_data;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            e_data = (m_active && m_k == 1) ? m_a : (m_active && m_k == 2) ? m_b : '0;
            check("cmd_ready", bus.cmd_ready, !m_active);
            check("busy", bus.busy, m_active);
            check("store_a", bus.store_a, m_active && m_k == 1);
            check("store_b", bus.store_b, m_active && m_k == 2);
            check("start", bus.start, m_active && m_k >= 3 && m_k <= 3 + m_w);
            check("alu_data", bus.alu_data, e_data);
            check("opcode_value", bus.opcode_value, m_op);
            check("rsp_valid", bus.rsp_valid, m_active && m_k == 4 + m_w);
            check("rsp_result", bus.rsp_result, m_res);
            check("rsp_overflow", bus.rsp_overflow, m_ov);
            check("rsp_error", bus.rsp_error, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.alu_done = 1'b0; bus.result = '0; bus.overflow = 1'b0; bus.rsp_ready = 1'b0;
        nd = 1; nres = '0; nov = 1'b0; noise = 1'b0;
        model_reset();
        #3;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_store_a", bus.store_a, 0);
        check("rst_store_b", bus.store_b, 0);
        check("rst_start", bus.start, 0);
        check("rst_alu_data", bus.alu_data, 0);
        check("rst_opcode", bus.opcode_value, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_overflow", bus.rsp_overflow, 0);
        check("rst_rsp_error", bus.rsp_error, 0);
        #19 rst = 1'b0;
        chk_en = 1'b1;
        noise = 1'b1;
        tick();

        // ADD 7F+01 with overflow, done on first WAIT cycle.
        issue(2'b00, 8'h7F, 8'h01, 1, 8'h80, 1'b1);
        check("add_store_a", bus.store_a, 1);
        check("add_alu_data_a", bus.alu_data, 8'h7F);
        tick();
        check("add_store_b", bus.store_b, 1);
        check("add_alu_data_b", bus.alu_data, 8'h01);
        tick();
        check("add_start", bus.start, 1);
        wait_rsp(n);
        check("add_latency", n + 2, 4);
        check("add_result", bus.rsp_result, 8'h80);
        check("add_overflow", bus.rsp_overflow, 1);
        check("add_error", bus.rsp_error, 0);
        drain();

        // PAR with datapath overflow: response overflow forced low. Then hold RESP.
        issue(2'b10, 8'h12, 8'h34, 2, 8'h3C, 1'b1);
        wait_rsp(n);
        check("par_result", bus.rsp_result, 8'h3C);
        check("par_overflow", bus.rsp_overflow, 0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_a = 8'h50; bus.cmd_b = 8'h20;
        nd = 3; nres = 8'h30; nov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rsp_result", bus.rsp_result, 8'h3C);
            check("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("release_busy", bus.busy, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("next_accept_store_a", bus.store_a, 1);
        check("next_accept_data", bus.alu_data, 8'h50);
        wait_rsp(n);
        check("sub_result", bus.rsp_result, 8'h30);
        drain();

        // Timeout: alu_done never arrives.
        noise = 1'b0;
        issue(2'b00, 8'h01, 8'h02, NEVER, 8'hFF, 1'b1);
        wait_rsp(n);
        check("tmo_latency", n, 18);
        check("tmo_error", bus.rsp_error, 1);
        check("tmo_result", bus.rsp_result, 0);
        drain();

        // Done on the final allowed WAIT cycle wins over timeout.
        issue(2'b01, 8'h09, 8'h04, TMO, 8'hA5, 1'b0);
        wait_rsp(n);
        check("edge_latency", n, 18);
        check("edge_error", bus.rsp_error, 0);
        check("edge_result", bus.rsp_result, 8'hA5);
        drain();

        // Reset pulse in the middle of WAIT.
        issue(2'b11, 8'hC3, 8'h3C, NEVER, 8'h00, 1'b0);
        for (int i = 0; i < 20 && m_k < 6; i++) tick();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_start", bus.start, 0);
        check("mid_rst_opcode", bus.opcode_value, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_error", bus.rsp_error, 0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        model_reset();
        #1 rst = 1'b0;
        noise = 1'b1;
        issue(2'b00, 8'h10, 8'h20, 2, 8'h30, 1'b0);
        wait_rsp(n);
        check("post_rst_result", bus.rsp_result, 8'h30);
        check("post_rst_error", bus.rsp_error, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            tick();
            bus.cmd_valid = 1'($urandom);
            bus.cmd_op    = 2'($urandom);
            bus.cmd_a     = DW'($urandom);
            bus.cmd_b     = DW'($urandom);
            bus.rsp_ready = ($urandom % 3) == 0;
            r = int'($urandom % 8);
            nd = (r < 5) ? r + 1 : (r == 5) ? TMO : (r == 6) ? TMO - 1 : NEVER;
            nres = DW'($urandom);
            nov  = 1'($urandom);
        end
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
